// File: rtl/hazard_grid_pkg.sv
// Shared types and derived-geometry helpers for the hazard occupancy-grid accumulator.
package hazard_grid_pkg;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    PAINT  = 2'd1,
    EMIT   = 2'd2
  } state_e;

  function automatic int grid_rows(input int coord_w, input int cell_h_log2);
    return 1 << (coord_w - cell_h_log2);
  endfunction

  function automatic int grid_cols(input int coord_w, input int cell_w_log2);
    return 1 << (coord_w - cell_w_log2);
  endfunction

  function automatic int count_width(input int max_hazards);
    return $clog2(max_hazards + 1);
  endfunction

endpackage

// File: rtl/hazard_row_mask.sv
// Turns an inclusive column-index range into a contiguous per-row cell mask.
module hazard_row_mask #(
  parameter int COL_IDX_W = 3
) (
  input  logic [COL_IDX_W-1:0]      col_lo_i,
  input  logic [COL_IDX_W-1:0]      col_hi_i,
  output logic [(1<<COL_IDX_W)-1:0] mask_o
);

  localparam int NCOLS = 1 << COL_IDX_W;

  always_comb begin
    for (int c = 0; c < NCOLS; c++) begin
      mask_o[c] = (c >= int'(col_lo_i)) && (c <= int'(col_hi_i));
    end
  end

endmodule

// File: rtl/hazard_grid_accumulator.sv
// Streams hazard boxes in, paints one coarse grid row per cycle, and emits the
// merged per-frame occupancy map with box count and error flags.
module hazard_grid_accumulator
  import hazard_grid_pkg::*;
#(
  parameter int COORD_W     = 5,
  parameter int CELL_W_LOG2 = 2,
  parameter int CELL_H_LOG2 = 3,
  parameter int MAX_HAZARDS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [COORD_W-1:0]         in_top,
  input  logic [COORD_W-1:0]         in_left,
  input  logic [COORD_W-1:0]         in_bottom,
  input  logic [COORD_W-1:0]         in_right,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [grid_rows(COORD_W, CELL_H_LOG2)*grid_cols(COORD_W, CELL_W_LOG2)-1:0] out_map,
  output logic [count_width(MAX_HAZARDS)-1:0] out_count,
  output logic                       out_overflow,
  output logic                       out_malformed
);

  localparam int ROW_W     = COORD_W - CELL_H_LOG2;
  localparam int COL_W     = COORD_W - CELL_W_LOG2;
  localparam int GRID_ROWS = grid_rows(COORD_W, CELL_H_LOG2);
  localparam int GRID_COLS = grid_cols(COORD_W, CELL_W_LOG2);
  localparam int CNT_W     = count_width(MAX_HAZARDS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HAZARDS);

  state_e                             state_q, state_d;
  logic [GRID_ROWS-1:0][GRID_COLS-1:0] map_q, map_d;
  logic [CNT_W-1:0]                   count_q, count_d;
  logic                               ovf_q, ovf_d;
  logic                               mal_q, mal_d;
  logic [ROW_W-1:0]                   cur_row_q, cur_row_d;
  logic [ROW_W-1:0]                   row_hi_q, row_hi_d;
  logic [COL_W-1:0]                   col_lo_q, col_lo_d;
  logic [COL_W-1:0]                   col_hi_q, col_hi_d;
  logic                               last_q, last_d;

  logic                 box_malformed;
  logic                 box_paints;
  logic [GRID_COLS-1:0] row_mask;

  hazard_row_mask #(.COL_IDX_W(COL_W)) u_row_mask (
    .col_lo_i (col_lo_q),
    .col_hi_i (col_hi_q),
    .mask_o   (row_mask)
  );

  assign in_ready      = (state_q == ACCEPT) && !rst;
  assign out_valid     = (state_q == EMIT);
  assign out_map       = map_q;
  assign out_count     = count_q;
  assign out_overflow  = ovf_q;
  assign out_malformed = mal_q;

  assign box_malformed = (in_top > in_bottom) || (in_left > in_right);
  assign box_paints    = !box_malformed && (count_q != CNT_MAX);

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    map_d     = map_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    mal_d     = mal_q;
    cur_row_d = cur_row_q;
    row_hi_d  = row_hi_q;
    col_lo_d  = col_lo_q;
    col_hi_d  = col_hi_q;
    last_d    = last_q;
    unique case (state_q)
      ACCEPT: begin
        if (in_valid && in_ready) begin
          cur_row_d = in_top[COORD_W-1:CELL_H_LOG2];
          row_hi_d  = in_bottom[COORD_W-1:CELL_H_LOG2];
          col_lo_d  = in_left[COORD_W-1:CELL_W_LOG2];
          col_hi_d  = in_right[COORD_W-1:CELL_W_LOG2];
          last_d    = in_last;
          if (box_malformed) mal_d = 1'b1;
          // A box arriving with the counter already full is counted as overflow only.
          if (count_q == CNT_MAX) ovf_d = 1'b1;
          else                    count_d = count_q + CNT_W'(1);
          if (box_paints)   state_d = PAINT;
          else if (in_last) state_d = EMIT;
        end
      end
      PAINT: begin
        map_d[cur_row_q] = map_q[cur_row_q] | row_mask;
        if (cur_row_q == row_hi_q) state_d = last_q ? EMIT : ACCEPT;
        else                       cur_row_d = cur_row_q + ROW_W'(1);
      end
      EMIT: begin
        if (out_ready) begin
          state_d = ACCEPT;
          map_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          mal_d   = 1'b0;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  // NOTE: the grid is plain flops, not a RAM, so it is cleared by the async reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCEPT;
      map_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      mal_q     <= 1'b0;
      cur_row_q <= '0;
      row_hi_q  <= '0;
      col_lo_q  <= '0;
      col_hi_q  <= '0;
      last_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register sees the pre-edge value of the others.
      state_q   <= state_d;
      map_q     <= map_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      mal_q     <= mal_d;
      cur_row_q <= cur_row_d;
      row_hi_q  <= row_hi_d;
      col_lo_q  <= col_lo_d;
      col_hi_q  <= col_hi_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_hazard_grid_accumulator.sv
// Directed and randomized checks of hazard_grid_accumulator against a pixel-level frame model.
module tb_hazard_grid_accumulator;

  localparam int MAXH   = 16;
  localparam int CELL_W = 4;
  localparam int CELL_H = 8;
  localparam int COLS   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [4:0]  in_top, in_left, in_bottom, in_right;
  logic        out_valid, out_ready;
  logic [31:0] out_map;
  logic [4:0]  out_count;
  logic        out_overflow, out_malformed;

  hazard_grid_accumulator dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_top        (in_top),
    .in_left       (in_left),
    .in_bottom     (in_bottom),
    .in_right      (in_right),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_map       (out_map),
    .out_count     (out_count),
    .out_overflow  (out_overflow),
    .out_malformed (out_malformed)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame model: stall counts busy cycles after a painting box; done means the frame awaits pickup.
  int          m_stall = 0;
  bit          m_done  = 1'b0;
  logic [31:0] m_map   = '0;
  int          m_count = 0;
  bit          m_ovf   = 1'b0;
  bit          m_mal   = 1'b0;

  task automatic model_clear();
    m_map = '0; m_count = 0; m_ovf = 1'b0; m_mal = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_box(input int t, input int l, input int b, input int r, input bit last);
    bit shape_bad;
    shape_bad = (t > b) || (l > r);
    if (shape_bad) m_mal = 1'b1;
    if (m_count == MAXH) m_ovf = 1'b1;
    else begin
      m_count++;
      if (!shape_bad) begin
        for (int y = t; y <= b; y++)
          for (int x = l; x <= r; x++)
            m_map[(y / CELL_H) * COLS + (x / CELL_W)] = 1'b1;
        m_stall = (b / CELL_H) - (t / CELL_H) + 1;
      end
    end
    if (last) m_done = 1'b1;
  endtask

  always @(negedge clk) begin
    bit e_ready, e_valid;
    if (rst) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_map", out_map, 0);
      check("rst_out_count", out_count, 0);
      check("rst_flags", {out_overflow, out_malformed}, 0);
      m_stall = 0;
      model_clear();
    end else begin
      e_ready = (m_stall == 0) && !m_done;
      e_valid = (m_stall == 0) && m_done;
      check("in_ready", in_ready, e_ready);
      check("out_valid", out_valid, e_valid);
      if (e_valid) begin
        check("out_map", out_map, m_map);
        check("out_count", out_count, m_count);
        check("out_overflow", out_overflow, m_ovf);
        check("out_malformed", out_malformed, m_mal);
      end
      if (m_stall > 0) m_stall--;
      else if (m_done) begin
        if (out_ready) model_clear();
      end else if (in_valid) begin
        model_box(in_top, in_left, in_bottom, in_right, in_last);
      end
    end
  end

  int          acc_cyc, f_vcyc;
  logic [31:0] f_map;
  int          f_count;
  bit          f_ovf, f_mal;

  // Entered and left at posedge+1; holds the box until the DUT takes it.
  task automatic send_box(input int t, input int l, input int b, input int r, input bit last);
    int n;
    n = 0;
    in_top = 5'(t); in_left = 5'(l); in_bottom = 5'(b); in_right = 5'(r);
    in_last = last; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        break;
      end
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_frame(input int hold);
    int n;
    n = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL frame_timeout: out_valid stayed 0 for %0d cycles", n);
        break;
      end
    end
    f_vcyc = cyc; f_map = out_map; f_count = out_count;
    f_ovf = out_overflow; f_mal = out_malformed;
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_top = '0; in_left = '0; in_bottom = '0; in_right = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Two boxes merged into one frame.
    send_box(1, 1, 5, 5, 1'b0);
    send_box(3, 17, 7, 25, 1'b1);
    wait_frame(0);
    check("t1_map", f_map, 32'h0000_0073);
    check("t1_count", f_count, 2);
    check("t1_flags", {f_ovf, f_mal}, 0);
    check("t1_latency", f_vcyc - acc_cyc, 2);

    // Full-frame box paints all four rows.
    send_box(0, 0, 31, 31, 1'b1);
    wait_frame(0);
    check("t2_map", f_map, 32'hFFFF_FFFF);
    check("t2_latency", f_vcyc - acc_cyc, 5);

    // Malformed box paints nothing but is counted.
    send_box(9, 0, 4, 3, 1'b1);
    wait_frame(0);
    check("t3_map", f_map, 0);
    check("t3_count", f_count, 1);
    check("t3_flags", {f_ovf, f_mal}, 2'b01);
    check("t3_latency", f_vcyc - acc_cyc, 1);

    // Eighteen single-cell boxes: the last two overflow and stay unpainted.
    for (int i = 0; i < 18; i++)
      send_box((i / COLS) * CELL_H, (i % COLS) * CELL_W, (i / COLS) * CELL_H, (i % COLS) * CELL_W, i == 17);
    wait_frame(0);
    check("t4_map", f_map, 32'h0000_FFFF);
    check("t4_count", f_count, 16);
    check("t4_flags", {f_ovf, f_mal}, 2'b10);

    // Result held for five cycles, then the next frame starts clean.
    send_box(8, 0, 15, 31, 1'b1);
    wait_frame(5);
    check("t5_map", f_map, 32'h0000_FF00);
    send_box(24, 28, 31, 31, 1'b1);
    wait_frame(0);
    check("t5_next_map", f_map, 32'h8000_0000);
    check("t5_next_count", f_count, 1);

    // Reset during painting of a four-row box.
    send_box(0, 0, 31, 31, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t6_map_in_rst", out_map, 0);
    check("t6_valid_in_rst", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_ready_after", in_ready, 1);
    @(posedge clk); #1;
    send_box(1, 1, 5, 5, 1'b1);
    wait_frame(0);
    check("t6_map", f_map, 32'h0000_0003);
    check("t6_count", f_count, 1);

    // Randomized frames, some longer than the box limit, some with malformed boxes.
    for (int f = 0; f < 40; f++) begin
      int nb;
      nb = $urandom_range(1, 20);
      for (int i = 0; i < nb; i++) begin
        int t, l, b, r, tmp;
        t = $urandom_range(0, 31); b = $urandom_range(0, 31);
        l = $urandom_range(0, 31); r = $urandom_range(0, 31);
        if ($urandom_range(0, 7) != 0) begin
          if (t > b) begin tmp = t; t = b; b = tmp; end
          if (l > r) begin tmp = l; l = r; r = tmp; end
        end
        if ($urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
        send_box(t, l, b, r, i == nb - 1);
      end
      wait_frame($urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_grid_accumulator.md
# hazard_grid_accumulator

Parametrised, sequential successor to the combinational hazard encoder: accepts hazard bounding boxes one at a time over a valid/ready stream and rasterises each into a coarse occupancy grid, one grid row per cycle. When the box flagged last in a frame has been painted, it presents the frame's occupancy map, box count and error flags on an output valid/ready port. It sits between the hazard detector and the spiking-input mapper, replacing the fixed 16-box, 2×16-bit encoder.

## Interface
- COORD_W, 5: pixel coordinate width; the frame is 2^COORD_W × 2^COORD_W pixels.
- CELL_W_LOG2, 2: log2 of cell width in pixels; GRID_COLS = 2^(COORD_W-CELL_W_LOG2).
- CELL_H_LOG2, 3: log2 of cell height in pixels; GRID_ROWS = 2^(COORD_W-CELL_H_LOG2).
- MAX_HAZARDS, 16: boxes painted per frame; further boxes are dropped.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  box presented.
- in_ready  out  1  block can accept a box.
- in_top, in_left, in_bottom, in_right  in  COORD_W each  inclusive pixel bounds.
- in_last  in  1  box is the last of its frame.
- out_valid  out  1  frame result available.
- out_ready  in  1  consumer takes the result.
- out_map  out  GRID_ROWS*GRID_COLS  occupancy; bit index = row*GRID_COLS + col.
- out_count  out  clog2(MAX_HAZARDS+1)  boxes accepted this frame, saturating at MAX_HAZARDS.
- out_overflow  out  1  more than MAX_HAZARDS boxes were received.
- out_malformed  out  1  at least one box had top>bottom or left>right.

## Operation
- FSM states: ACCEPT, PAINT, EMIT. Reset state: ACCEPT.
- in_ready = (state==ACCEPT) && !rst. in_ready is 0 during PAINT and EMIT.
- On acceptance (in_valid && in_ready):
  - Compute row_lo=top>>CELL_H_LOG2, row_hi=bottom>>CELL_H_LOG2, col_lo=left>>CELL_W_LOG2, col_hi=right>>CELL_W_LOG2. Latch these values and in_last.
  - If the box is well-formed and count<MAX_HAZARDS: increment count, go to PAINT.
  - If the box is malformed: set malformed (sticky), increment count (saturating), paint nothing.
  - If count==MAX_HAZARDS: set overflow (sticky), paint nothing.
  - Non-painting boxes go to EMIT if in_last, otherwise stay in ACCEPT.
- PAINT: each cycle OR the column mask [col_lo..col_hi] into map row cur_row, starting at cur_row=row_lo. When cur_row==row_hi, go to EMIT if the latched last is set, otherwise to ACCEPT.
- EMIT: out_valid=1. out_map, out_count and the flags are held stable until out_ready. On the handshake, clear map, count and flags and go to ACCEPT.
- Overlapping boxes are merged by OR. Duplicate cells are not errors.
- Coordinates are unsigned. Because of the shift arithmetic, out-of-grid indices are impossible.

## Timing
- Reset values: in_ready 0 while rst is high, out_valid 0, out_map 0, out_count 0, out_overflow 0, out_malformed 0.
- A painting box accepted at cycle T paints rows at T+1 … T+1+(row_hi-row_lo).
- in_ready returns to 1 at T+2+(row_hi-row_lo). If the box was last, out_valid rises at that cycle instead.
- A non-painting last box accepted at T gives out_valid at T+1.
- out_valid is never deasserted without out_ready. in_ready returns the cycle after the out handshake.
- rst asserted in any state aborts immediately. The partial map is discarded and all outputs return to their reset values.

## Structure
- Package hazard_grid_pkg: state enum (ACCEPT, PAINT, EMIT), and derived-constant functions for GRID_ROWS, GRID_COLS and count width.
- Sub-module hazard_row_mask: combinational; maps (col_lo, col_hi) to a GRID_COLS-bit contiguous mask. It is instanced once.

## Test plan
- Default parameters. Box (1,1,5,5) then box (3,17,7,25) with in_last → out_map=0x00000073, out_count=2, flags 0. out_valid 2 cycles after the second acceptance.
- Single box (0,0,31,31), last → out_map=0xFFFFFFFF, 4 PAINT cycles, out_valid at T+5.
- Malformed box (top=9, bottom=4), last → out_map=0, out_count=1, out_malformed=1, out_valid at T+1.
- 18 well-formed single-cell boxes → out_count=16, out_overflow=1. Boxes 17 and 18 are absent from out_map.
- Hold out_ready=0 for 5 cycles in EMIT → out_map and flags stable, in_ready=0. The next frame starts from an all-zero map.
- Assert rst mid-PAINT of a 4-row box → all outputs reset immediately. in_ready=1 the first cycle after release; the next frame is unaffected by the aborted box.
